// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizer, tick-sampled debounce, one-cycle press
// pulse and optional hold-to-auto-repeat. One instance per front-panel button.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   button_in     raw asynchronous button, active-high
//   repeat_en     1 = auto-repeat while held, 0 = single pulse per press
//   level_out     debounced button level
//   pulse_out     one-cycle pulse per press and per repeat
//   repeat_active high from the first repeat pulse until release
module button_conditioner #(
  parameter int unsigned TICK_DIV     = 315000,
  parameter int unsigned STABLE_TICKS = 3,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  input  logic repeat_en,
  output logic level_out,
  output logic pulse_out,
  output logic repeat_active
);

  localparam int unsigned TickW   = $clog2(TICK_DIV + 1);
  localparam int unsigned DebW    = $clog2(STABLE_TICKS + 1);
  localparam int unsigned HoldMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned HoldW   = $clog2(HoldMax + 1);

  localparam logic [TickW-1:0] TickLast  = TickW'(TICK_DIV - 1);
  localparam logic [DebW-1:0]  DebLast   = DebW'(STABLE_TICKS - 1);
  localparam logic [HoldW-1:0] DelayLast = HoldW'(REPEAT_DELAY - 1);
  localparam logic [HoldW-1:0] DelayMax  = HoldW'(REPEAT_DELAY);
  localparam logic [HoldW-1:0] RateLast  = HoldW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

  logic             sync1_q, btn_s_q;
  logic [TickW-1:0] tick_cnt_q;
  logic             tick;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic             level_q, level_d;
  logic             rise, fall;
  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             pulse_q, pulse_d;
  logic             active_q, active_d;

  // Two-flop synchronizer and free-running sample tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      btn_s_q    <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      sync1_q    <= button_in;
      btn_s_q    <= sync1_q;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TickW'(1);
    end
  end

  assign tick = (tick_cnt_q == TickLast);

  // Debounce: the level flips only after STABLE_TICKS consecutive differing samples.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    level_d   = level_q;
    if (tick) begin
      if (btn_s_q == level_q) begin
        deb_cnt_d = '0;
      end else if (deb_cnt_q == DebLast) begin
        level_d   = ~level_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DebW'(1);
      end
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  // Press / repeat FSM. A release flip always wins over a due repeat.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pulse_d    = 1'b0;
    active_d   = active_q;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          pulse_d    = 1'b1;
          hold_cnt_d = '0;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (fall) begin
          state_d    = StIdle;
          hold_cnt_d = '0;
          active_d   = 1'b0;
        end else if (tick) begin
          if (repeat_en && (hold_cnt_q >= DelayLast)) begin
            pulse_d    = 1'b1;
            active_d   = 1'b1;
            hold_cnt_d = '0;
            state_d    = StRepeat;
          end else if (hold_cnt_q < DelayMax) begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end
        end
      end
      StRepeat: begin
        if (fall) begin
          state_d    = StIdle;
          hold_cnt_d = '0;
          active_d   = 1'b0;
        end else if (tick) begin
          // The repeat period keeps running with repeat_en low; it only gates the pulse.
          if (hold_cnt_q >= RateLast) begin
            hold_cnt_d = '0;
            pulse_d    = repeat_en;
          end else begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end
        end
      end
      default: begin
        state_d    = StIdle;
        hold_cnt_d = '0;
        active_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt_q  <= '0;
      level_q    <= 1'b0;
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      pulse_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      level_q    <= level_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      pulse_q    <= pulse_d;
      active_q   <= active_d;
    end
  end

  assign level_out     = level_q;
  assign pulse_out     = pulse_q;
  assign repeat_active = active_q;

endmodule
